x2c_bcnt_rd_ctrl: RTL and testbench

//  Read-side sequencer for the 256x32 byte-count FIFO and its companion 64-bit packet data FIFO.

---
 rtl/x2c_bcnt_rd_ctrl.sv | 129 ++++++++++++
 tb/tb_x2c_bcnt_rd_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/x2c_bcnt_rd_ctrl.sv
// x2c_bcnt_rd_ctrl: pops one byte-count entry per packet, reads ceil(len/8) data words
// and streams them downstream with SOP/EOP/byte-valid tags through an output reg + 1-entry skid.
module x2c_bcnt_rd_ctrl #(
    parameter int DW        = 64,
    parameter int BCNT_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BYTES = 9600
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              bcnt_empty,
    output logic              bcnt_rdreq,
    input  logic [BCNT_W-1:0] bcnt_q,
    input  logic              dat_empty,
    output logic              dat_rdreq,
    input  logic [DW-1:0]     dat_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [2:0]        out_bval,
    output logic              err_len,
    output logic [31:0]       pkt_cnt
);
    typedef enum logic [1:0] {IDLE, LEN, XFER, DRAIN} state_t;
    state_t state_q, state_d;
    logic [LEN_W-3:0] words_q, words_d;
    logic [2:0] bval_q, bval_d;
    logic first_q, first_d;
    logic infl_q, sv_q, ov_q, err_q;
    logic [4:0] ftag_q, otag_q, stag_q;
    logic [DW-1:0] od_q, sd_q;
    logic [31:0] cnt_q;
    logic [LEN_W-1:0] len;
    logic [LEN_W:0] len_rnd;
    logic bad, accept, eop_acc, last_rd;
    logic [1:0] held_ap;
    logic unused_ok;

    assign len       = bcnt_q[LEN_W-1:0];
    assign len_rnd   = {1'b0, len} + (LEN_W+1)'(7);
    assign bad       = len == '0 || 32'(len) > 32'(MAX_BYTES);
    assign accept    = ov_q & out_ready;
    assign eop_acc   = accept & otag_q[3];
    assign last_rd   = words_q == (LEN_W-2)'(1);
    assign unused_ok = ^{bcnt_q[BCNT_W-1:LEN_W], len_rnd[2:0]};
    // tag bits: [4]=sop [3]=eop [2:0]=bval; occupancy counts words left after this cycle's accept
    assign held_ap    = {1'b0, ov_q} + {1'b0, sv_q} - {1'b0, accept};
    assign dat_rdreq  = state_q == XFER && words_q != '0 && !dat_empty && held_ap + {1'b0, infl_q} < 2'd2;
    assign bcnt_rdreq = !aclr && !bcnt_empty && (state_q == IDLE || (state_q == DRAIN && eop_acc));

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        bval_d  = bval_q;
        first_d = first_q;
        case (state_q)
            IDLE: if (bcnt_rdreq) state_d = LEN;
            LEN: begin
                state_d = bad ? IDLE : XFER;
                words_d = len_rnd[LEN_W:3];
                bval_d  = len[2:0];
                first_d = 1'b1;
            end
            XFER: if (dat_rdreq) begin
                words_d = words_q - (LEN_W-2)'(1);
                first_d = 1'b0;
                if (last_rd) state_d = DRAIN;
            end
            default: if (eop_acc) state_d = bcnt_rdreq ? LEN : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
            words_q <= '0;
            bval_q  <= '0;
            first_q <= 1'b0;
            infl_q  <= 1'b0;
            ftag_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            bval_q  <= bval_d;
            first_q <= first_d;
            infl_q  <= dat_rdreq;
            ftag_q  <= {first_q, last_rd, last_rd ? bval_q : 3'd0};
            err_q   <= state_q == LEN && bad;
            cnt_q   <= cnt_q + 32'(eop_acc);
        end
    end

    // Returning word goes to the output reg when it frees up, otherwise parks in the skid.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            ov_q   <= 1'b0;
            sv_q   <= 1'b0;
            od_q   <= '0;
            sd_q   <= '0;
            otag_q <= '0;
            stag_q <= '0;
        end else if (!ov_q || accept) begin
            ov_q   <= sv_q | infl_q;
            od_q   <= sv_q ? sd_q : dat_q;
            otag_q <= sv_q ? stag_q : ftag_q;
            sv_q   <= sv_q & infl_q;
            if (sv_q & infl_q) begin
                sd_q   <= dat_q;
                stag_q <= ftag_q;
            end
        end else if (infl_q) begin
            sv_q   <= 1'b1;
            sd_q   <= dat_q;
            stag_q <= ftag_q;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_sop   = otag_q[4];
    assign out_eop   = otag_q[3];
    assign out_bval  = otag_q[2:0];
    assign err_len   = err_q;
    assign pkt_cnt   = cnt_q;
endmodule

// File: tb/tb_x2c_bcnt_rd_ctrl.sv
// tb_x2c_bcnt_rd_ctrl: FIFO models plus a packet-level expected-word queue checked on every accept.
module tb_x2c_bcnt_rd_ctrl;
    typedef struct packed {
        logic [63:0] d;
        logic        sop;
        logic        eop;
        logic [2:0]  bval;
    } word_t;

    logic clk = 1'b0, aclr = 1'b1;
    logic bcnt_empty, bcnt_rdreq, dat_empty, dat_rdreq;
    logic [31:0] bcnt_q = '0;
    logic [63:0] dat_q = '0;
    logic out_valid, out_ready, out_sop, out_eop, err_len;
    logic [63:0] out_data;
    logic [2:0] out_bval;
    logic [31:0] pkt_cnt;

    logic [31:0] bq[$];
    logic [63:0] dq[$];
    word_t exp_q[$];
    int vectors = 0, errors = 0, cyc = 0, rd_seen = 0, errs_seen = 0, model_pkts = 0;
    int pkt_words = 0, pkt_id = 0, pop_cyc = 0, sop_cyc = 0, eop_cyc = 0, rd0 = 0, e0 = 0;
    bit need_first = 0, hold_prev = 0, rand_mode = 0, stall = 0;
    logic bcnt_emp_r = 1'b1, dat_emp_r = 1'b1;
    word_t prev_w, last_w, got, w;

    assign bcnt_empty = bcnt_emp_r;
    assign dat_empty  = dat_emp_r | stall;

    x2c_bcnt_rd_ctrl dut (
        .clk(clk), .aclr(aclr), .bcnt_empty(bcnt_empty), .bcnt_rdreq(bcnt_rdreq), .bcnt_q(bcnt_q),
        .dat_empty(dat_empty), .dat_rdreq(dat_rdreq), .dat_q(dat_q), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_bval(out_bval), .err_len(err_len), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Non-show-ahead FIFOs: data appears one clock after the read request.
    always @(posedge clk) begin
        cyc++;
        if (aclr) need_first = 0;
        if (bcnt_rdreq) begin
            check("bcnt_rd_nonempty", bq.size() != 0, 1);
            if (bq.size() != 0) bcnt_q <= bq.pop_front();
            pop_cyc = cyc;
            need_first = 1;
        end
        if (dat_rdreq) begin
            check("dat_rd_nonempty", dq.size() != 0 && !stall, 1);
            if (dq.size() != 0) dat_q <= dq.pop_front();
            rd_seen++;
            if (need_first) begin
                check("startup_lat", cyc - pop_cyc, 2);
                need_first = 0;
            end
        end
        bcnt_emp_r <= bq.size() == 0;
        dat_emp_r  <= dq.size() == 0;
    end

    always @(negedge clk) begin
        if (aclr) begin
            model_pkts = 0;
            hold_prev = 0;
        end else begin
            got = {out_data, out_sop, out_eop, out_bval};
            if (err_len) errs_seen++;
            check("pkt_cnt", pkt_cnt, model_pkts);
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_word", got, prev_w);
            end
            if (out_valid && out_ready) begin
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("word", got, w);
                    pkt_words = w.sop ? 1 : pkt_words + 1;
                    if (w.sop) sop_cyc = cyc;
                    if (w.eop) begin
                        model_pkts++;
                        eop_cyc = cyc;
                    end
                    last_w = got;
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_w = got;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic push_pkt(input int len, input logic [15:0] hi = 16'h0);
        int n = (len + 7) / 8;
        pkt_id++;
        for (int i = 0; i < n; i++) begin
            logic [63:0] d = {32'hD00D0000 | 32'(pkt_id), 32'(i)};
            dq.push_back(d);
            exp_q.push_back('{d, i == 0, i == n - 1, (i == n - 1) ? 3'(len % 8) : 3'd0});
        end
        bq.push_back({hi, 16'(len)});
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bq.size() != 0 || out_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_in_budget", n < budget, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_reads(input int target);
        for (int n = 0; n < 200 && rd_seen < target; n++) begin
            @(posedge clk);
            #1;
        end
        check("reads_reached", rd_seen >= target, 1);
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_word", {out_data, out_sop, out_eop, out_bval}, 0);
        check("rst_err", err_len, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_rdreq", {bcnt_rdreq, dat_rdreq}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 aclr = 1'b0;
        out_ready = 1'b1;

        push_pkt(1);
        wait_done(200);
        check("t1_pkt_cnt", pkt_cnt, 1);
        check("t1_tags", {last_w.sop, last_w.eop, last_w.bval}, 5'b11001);
        check("t1_words", pkt_words, 1);

        push_pkt(64);
        wait_done(200);
        check("t2_pkt_cnt", pkt_cnt, 2);
        check("t2_tags", {last_w.sop, last_w.eop, last_w.bval}, 5'b01000);
        check("t2_words", pkt_words, 8);
        check("t2_back_to_back", eop_cyc - sop_cyc, 7);

        push_pkt(9);
        push_pkt(17);
        wait_done(200);
        check("t3_pkt_cnt", pkt_cnt, 4);
        check("t3_tags", {last_w.sop, last_w.eop, last_w.bval}, 5'b01001);
        check("t3_words", pkt_words, 3);

        rand_mode = 1;
        push_pkt(100);
        wait_done(2000);
        rand_mode = 0;
        out_ready = 1'b1;
        check("t4_pkt_cnt", pkt_cnt, 5);
        check("t4_tags", {last_w.sop, last_w.eop, last_w.bval}, 5'b01100);
        check("t4_words", pkt_words, 13);

        rd0 = rd_seen;
        e0 = errs_seen;
        bq.push_back(32'd0);
        bq.push_back(32'd9601);
        wait_done(200);
        check("t5_err_pulses", errs_seen - e0, 2);
        check("t5_no_reads", rd_seen - rd0, 0);
        check("t5_pkt_cnt", pkt_cnt, 5);

        push_pkt(9600);
        push_pkt(8, 16'hABCD);
        wait_done(3000);
        check("t5b_pkt_cnt", pkt_cnt, 7);
        check("t5b_tags", {last_w.sop, last_w.eop, last_w.bval}, 5'b11000);
        check("t5b_no_err", errs_seen - e0, 2);

        rd0 = rd_seen;
        push_pkt(40);
        wait_reads(rd0 + 2);
        stall = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t6_drained", out_valid, 0);
        @(posedge clk);
        #1 stall = 0;
        wait_done(200);
        check("t6_pkt_cnt", pkt_cnt, 8);
        check("t6_words", pkt_words, 5);
        check("t6_tags", {last_w.sop, last_w.eop, last_w.bval}, 5'b01000);

        rd0 = rd_seen;
        push_pkt(64);
        wait_reads(rd0 + 3);
        aclr = 1'b1;
        bq.delete();
        dq.delete();
        exp_q.delete();
        check_reset_outputs();
        @(posedge clk);
        #1 aclr = 1'b0;
        push_pkt(20);
        wait_done(200);
        check("t7_pkt_cnt", pkt_cnt, 1);
        check("t7_words", pkt_words, 3);
        check("t7_tags", {last_w.sop, last_w.eop, last_w.bval}, 5'b01100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
